// File: rtl/ret_stack_pkg.sv
// Shared constants and operation decode for the return-address stack.
package ret_stack_pkg;

  localparam int RS_WIDTH = 12;
  localparam int RS_DEPTH = 8;

  typedef enum logic [1:0] {
    RS_NOP,
    RS_PUSH,
    RS_POP,
    RS_REPL
  } rs_op_e;

  function automatic rs_op_e decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return RS_PUSH;
      2'b01:   return RS_POP;
      2'b11:   return RS_REPL;
      default: return RS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ret_stack_mem.sv
// Return-stack storage: DEPTH x WIDTH registers, one sync write port, one async read port.
module ret_stack_mem #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ret_stack.sv
// Parametrised return-address stack with replace-top, clear and sticky error flags.
// Define RET_STACK_OVERWRITE_EN to make a push when full overwrite the oldest entry.
module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int WIDTH = RS_WIDTH,
  parameter int DEPTH = RS_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  input  logic             err_clr,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  rs_op_e           op;
  logic [CW-1:0]    count_n;
  logic             set_ov, set_un;
  logic             we;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] rdata;

`ifdef RET_STACK_OVERWRITE_EN
  logic [AW-1:0] base, base_n;
`else
  localparam logic [AW-1:0] base = '0;
`endif

  // Logical stack index -> physical slot, relative to base, modulo DEPTH.
  function automatic logic [AW-1:0] phys(input logic [AW-1:0] b, input logic [CW-1:0] idx);
    int unsigned s;
    s = 32'(b) + 32'(idx);
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return AW'(s);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign raddr = empty ? '0 : phys(base, count - CW'(1));
  assign top   = empty ? '0 : rdata;

  always_comb begin
    op      = decode_op(push, pop);
    we      = 1'b0;
    waddr   = raddr;
    count_n = count;
    set_ov  = 1'b0;
    set_un  = 1'b0;
`ifdef RET_STACK_OVERWRITE_EN
    base_n  = base;
`endif
    if (clear) begin
      count_n = '0;
    end else begin
      case (op)
        RS_PUSH: begin
          if (!full) begin
            we      = reset;
            waddr   = phys(base, count);
            count_n = count + CW'(1);
          end else begin
            set_ov = 1'b1;
`ifdef RET_STACK_OVERWRITE_EN
            // Oldest entry sits at base; overwrite it and rotate base so it becomes newest.
            we     = reset;
            waddr  = base;
            base_n = (base == AW'(DEPTH - 1)) ? '0 : base + AW'(1);
`endif
          end
        end
        RS_POP: begin
          if (!empty) count_n = count - CW'(1);
          else        set_un  = 1'b1;
        end
        RS_REPL: begin
          we = reset;
          if (empty) begin
            set_un  = 1'b1;
            waddr   = base;
            count_n = CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
`ifdef RET_STACK_OVERWRITE_EN
      base      <= '0;
`endif
    end else begin
      count     <= count_n;
      overflow  <= set_ov | (overflow & ~err_clr);
      underflow <= set_un | (underflow & ~err_clr);
`ifdef RET_STACK_OVERWRITE_EN
      base      <= base_n;
`endif
    end
  end

  ret_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_ret_stack.sv
// Self-checking bench for ret_stack (DEPTH=4) against a queue-based LIFO reference model.
module tb_ret_stack;

  localparam int W  = 12;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0, pop = 1'b0, clear = 1'b0, err_clr = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  top;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [W-1:0] q[$];
  logic         m_ov = 1'b0, m_un = 1'b0;

  ret_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (din),
    .clear     (clear),
    .err_clr   (err_clr),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] t;
    t = (q.size() == 0) ? '0 : q[q.size() - 1];
    chk({tag, ".top"},       32'(top),       32'(t));
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(q.size() == D));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ov));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_un));
  endtask

  // LIFO rules applied to a queue: back of queue is top of stack.
  task automatic model(input logic ps, input logic pp, input logic [W-1:0] d,
                       input logic cl, input logic ec, input logic rs);
    logic sov, sun;
    sov = 1'b0;
    sun = 1'b0;
    if (!rs) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      return;
    end
    if (cl) q.delete();
    else if (ps && pp) begin
      if (q.size() == 0) begin sun = 1'b1; q.push_back(d); end
      else q[q.size() - 1] = d;
    end else if (ps) begin
      if (q.size() < D) q.push_back(d);
      else begin
        sov = 1'b1;
`ifdef RET_STACK_OVERWRITE_EN
        void'(q.pop_front());
        q.push_back(d);
`endif
      end
    end else if (pp) begin
      if (q.size() > 0) void'(q.pop_back());
      else sun = 1'b1;
    end
    m_ov = sov | (m_ov & ~ec);
    m_un = sun | (m_un & ~ec);
  endtask

  task automatic step(input string tag, input logic ps, input logic pp, input logic [W-1:0] d,
                      input logic cl, input logic ec, input logic rs);
    push = ps; pop = pp; din = d; clear = cl; err_clr = ec; reset = rs;
    @(posedge clk);
    model(ps, pp, d, cl, ec, rs);
    #1;
    check_all(tag);
  endtask

  initial begin
    step("reset", 0, 0, '0, 0, 0, 0);

    step("push10", 1, 0, 12'h010, 0, 0, 1);
    step("push20", 1, 0, 12'h020, 0, 0, 1);
    step("push30", 1, 0, 12'h030, 0, 0, 1);
    step("pop1",   0, 1, '0, 0, 0, 1);
    step("pop2",   0, 1, '0, 0, 0, 1);
    step("pop3",   0, 1, '0, 0, 0, 1);

    for (int i = 1; i <= 4; i++) step("fill", 1, 0, W'(i), 0, 0, 1);
    step("push_full", 1, 0, 12'h005, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("drain", 0, 1, '0, 0, 0, 1);
    step("errclr_ov", 0, 0, '0, 0, 1, 1);

    step("pop_empty",      0, 1, '0, 0, 0, 1);
    step("errclr",         0, 0, '0, 0, 1, 1);
    step("errclr_popempt", 0, 1, '0, 0, 1, 1);
    step("errclr2",        0, 0, '0, 0, 1, 1);

    step("r_push10", 1, 0, 12'h010, 0, 0, 1);
    step("r_push20", 1, 0, 12'h020, 0, 0, 1);
    step("replace",  1, 1, 12'h0AA, 0, 0, 1);
    step("r_pop",    0, 1, '0, 0, 0, 1);
    step("r_pop2",   0, 1, '0, 0, 0, 1);
    step("repl_empty", 1, 1, 12'h0BB, 0, 0, 1);
    step("errclr3",  0, 0, '0, 0, 1, 1);

    step("c_push2", 1, 0, 12'h002, 0, 0, 1);
    step("c_push3", 1, 0, 12'h003, 0, 0, 1);
    step("clear_push", 1, 0, 12'h007, 1, 0, 1);

    for (int i = 0; i < 5; i++) step("ov_fill", 1, 0, W'(12'h100 + i), 0, 0, 1);
    step("ov_pop", 0, 1, '0, 0, 0, 1);
    reset = 1'b0;
    #3;
    check_all("reset_noedge");
    step("reset_push", 1, 0, 12'h0FF, 0, 0, 0);
    step("after_reset", 0, 0, '0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      logic ps, pp, cl, ec, rs;
      ps = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 15) == 0);
      ec = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 63) != 0);
      step("rand", ps, pp, W'($urandom_range(0, 4095)), cl, ec, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
